// File: rtl/uart_dec_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_dec_rx_pkg
// Shared constants and types for the decimal UART receiver:
//   - ASCII codes the line parser reacts to
//   - parser and byte-receiver state encodings
//   - baud divisor derivation shared with the transmit side
//   - small helpers for digit classification
// -----------------------------------------------------------------------------
package uart_dec_rx_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;

  // Accumulator holds up to five decimal digits (99999 < 2^17).
  localparam int          ACC_W    = 17;
  localparam logic [16:0] DATA_MAX = 17'd65535;

  typedef enum logic [1:0] {
    P_IDLE,
    P_ACCUM,
    P_DISCARD,
    P_EMIT
  } parse_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_e;

  // System clocks per serial bit; same derivation as the uart_tx side.
  function automatic int baud_cnt_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

endpackage

// File: rtl/uart_dec_rx_if.sv
// -----------------------------------------------------------------------------
// uart_dec_rx_if
// Result bus of the decimal UART receiver.
//   data       : last accepted 16-bit value, held until the next accept
//   data_valid : 1-cycle pulse, data updated this cycle
//   parse_err  : 1-cycle pulse, a line was rejected
// master = the receiver driving results, slave = the consumer.
// -----------------------------------------------------------------------------
interface uart_dec_rx_if;
  logic [15:0] data;
  logic        data_valid;
  logic        parse_err;

  modport master (
    output data,
    output data_valid,
    output parse_err
  );

  modport slave (
    input data,
    input data_valid,
    input parse_err
  );
endinterface

// File: rtl/uart_dec_rx_uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 byte receiver. Double-flop synchronises the asynchronous line, detects
// the start bit on a falling edge, confirms it low at mid-bit, then samples
// eight data bits (LSB first) and the stop bit at their centres.
// Ports:
//   sys_clk, sys_rst (sync, active-high)
//   uart_rxd      : asynchronous serial input, idle high
//   uart_rx_data  : received byte, valid while uart_rx_done is high
//   uart_rx_done  : 1-cycle pulse at the stop-bit centre
//   uart_rx_ferr  : high with uart_rx_done when the stop bit sampled low
// -----------------------------------------------------------------------------
module uart_rx
  import uart_dec_rx_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rxd,
  output logic [7:0] uart_rx_data,
  output logic       uart_rx_done,
  output logic       uart_rx_ferr
);

  localparam int CPB   = baud_cnt_div(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W = $clog2(CPB);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CPB - 1);

  logic             rxd_meta_q, rxd_sync_q, rxd_prev_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;

  // Synchroniser plus one extra stage for edge detection; all idle high.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= R_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    done_d     = 1'b0;
    ferr_d     = 1'b0;

    case (state_q)
      R_IDLE: begin
        if (rxd_prev_q && !rxd_sync_q) begin
          state_d    = R_START;
          baud_cnt_d = '0;
        end
      end

      // Half a bit in: a line that bounced back high was a glitch.
      R_START: begin
        if (baud_cnt_q == HALF_M1) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = rxd_sync_q ? R_IDLE : R_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end

      // Counter is re-based at mid start bit, so each wrap lands on a bit centre.
      R_DATA: begin
        if (baud_cnt_q == FULL_M1) begin
          baud_cnt_d = '0;
          shift_d    = {rxd_sync_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = R_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end

      R_STOP: begin
        if (baud_cnt_q == FULL_M1) begin
          baud_cnt_d = '0;
          data_d     = shift_q;
          done_d     = 1'b1;
          ferr_d     = !rxd_sync_q;
          state_d    = R_IDLE;
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end

      default: state_d = R_IDLE;
    endcase
  end

  assign uart_rx_data = data_q;
  assign uart_rx_done = done_q;
  assign uart_rx_ferr = ferr_q;

endmodule

// File: rtl/uart_dec_rx.sv
// -----------------------------------------------------------------------------
// uart_dec_rx
// Receives CR-terminated ASCII decimal strings over an 8N1 line and returns
// the parsed 16-bit unsigned value. LF bytes are ignored, empty lines are
// ignored, anything malformed or out of range produces a parse_err pulse.
// Ports:
//   sys_clk, sys_rst (sync, active-high)
//   uart_rxd : asynchronous serial input, idle high
//   dec_o    : result bus (data / data_valid / parse_err)
// Parameters:
//   CLK_FREQ, BAUD_RATE : line timing, CLK_FREQ/BAUD_RATE >= 16
//   MAX_DIGITS          : longest accepted digit string, leading zeros count
// -----------------------------------------------------------------------------
module uart_dec_rx
  import uart_dec_rx_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int MAX_DIGITS = 5
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          uart_rxd,
  uart_dec_rx_if.master dec_o
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_ferr;

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_rx (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .uart_rxd     (uart_rxd),
    .uart_rx_data (rx_data),
    .uart_rx_done (rx_done),
    .uart_rx_ferr (rx_ferr)
  );

  // acc*10 + d without a multiplier; the shifted terms fit 20 bits and the
  // result never exceeds 99999 because at most MAX_DIGITS-1 digits precede d.
  function automatic logic [ACC_W-1:0] mul10_add(input logic [ACC_W-1:0] a,
                                                 input logic [3:0]       d);
    logic [19:0] w;
    w = ({3'b000, a} << 3) + ({3'b000, a} << 1);
    return w[ACC_W-1:0] + {13'd0, d};
  endfunction

  parse_state_e     state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bad_q, bad_d;
  logic [15:0]      data_q, data_d;
  logic             dv_q, dv_d;
  logic             pe_q, pe_d;

  logic             rx_is_digit;
  logic [7:0]       rx_off;
  logic [3:0]       rx_digit;
  logic             rx_is_cr;
  logic             rx_is_lf;

  assign rx_is_digit = is_digit(rx_data);
  assign rx_off      = rx_data - ASCII_0;
  assign rx_digit    = rx_off[3:0];
  assign rx_is_cr    = (rx_data == ASCII_CR);
  assign rx_is_lf    = (rx_data == ASCII_LF);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= P_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      pe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      pe_q    <= pe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    pe_d    = 1'b0;

    case (state_q)
      P_IDLE: begin
        if (rx_done) begin
          if (rx_ferr) begin
            state_d = P_DISCARD;
          end else if (rx_is_digit) begin
            acc_d   = {13'd0, rx_digit};
            cnt_d   = CNT_W'(1);
            state_d = P_ACCUM;
          end else if (!(rx_is_cr || rx_is_lf)) begin
            state_d = P_DISCARD;
          end
        end
      end

      P_ACCUM: begin
        if (rx_done) begin
          if (rx_ferr) begin
            state_d = P_DISCARD;
          end else if (rx_is_digit) begin
            if (cnt_q == CNT_W'(MAX_DIGITS)) begin
              state_d = P_DISCARD;
            end else begin
              acc_d = mul10_add(acc_q, rx_digit);
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (rx_is_cr) begin
            bad_d   = 1'b0;
            state_d = P_EMIT;
          end else if (!rx_is_lf) begin
            state_d = P_DISCARD;
          end
        end
      end

      // Rejected lines still pass through EMIT so the error pulse has the
      // same CR-to-pulse latency as an accepted value.
      P_DISCARD: begin
        if (rx_done && !rx_ferr && rx_is_cr) begin
          bad_d   = 1'b1;
          state_d = P_EMIT;
        end
      end

      P_EMIT: begin
        if (bad_q || (acc_q > DATA_MAX)) begin
          pe_d = 1'b1;
        end else begin
          dv_d   = 1'b1;
          data_d = acc_q[15:0];
        end
        acc_d   = '0;
        cnt_d   = '0;
        bad_d   = 1'b0;
        state_d = P_IDLE;
      end

      default: state_d = P_IDLE;
    endcase
  end

  assign dec_o.data       = data_q;
  assign dec_o.data_valid = dv_q;
  assign dec_o.parse_err  = pe_q;

endmodule
